// File: rtl/axi4_lite_read_master_engine.sv
// AXI4-Lite read-master engine: command queue, AR issue FSM with per-command
// ARVALID delay, outstanding tracking, RREADY policy, response port and
// ARREADY/RVALID wait-timeout monitors.
module axi4_lite_read_master_engine #(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int DELAY_WIDTH       = 5,
    parameter int CMD_DEPTH         = 4,
    parameter int MAX_OUTSTANDING   = 4,
    parameter int DEFAULT_READY     = 0,
    parameter int MAX_DELAY_ARREADY = 16,
    parameter int MAX_DELAY_RVALID  = 16
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0]               cmd_addr,
    input  logic [2:0]                             cmd_prot,
    input  logic [DELAY_WIDTH-1:0]                 cmd_arvalid_delay,
    input  logic [DELAY_WIDTH-1:0]                 cmd_rready_delay,
    input  logic                                   cfg_blocking,
    input  logic [ADDRESS_WIDTH-1:0]               cfg_min_addr,
    input  logic [ADDRESS_WIDTH-1:0]               cfg_max_addr,
    input  logic                                   tmo_clear,
    output logic [ADDRESS_WIDTH-1:0]               araddr,
    output logic [2:0]                             arprot,
    output logic                                   arvalid,
    input  logic                                   arready,
    input  logic [DATA_WIDTH-1:0]                  rdata,
    input  logic [1:0]                             rresp,
    input  logic                                   rvalid,
    output logic                                   rready,
    output logic                                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                  rsp_data,
    output logic [1:0]                             rsp_resp,
    output logic                                   rsp_err,
    output logic                                   addr_err,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   arready_timeout,
    output logic                                   rvalid_timeout
);
    localparam int QAW = $clog2(CMD_DEPTH);
    localparam int QCW = $clog2(CMD_DEPTH + 1);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int DIW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int ATW = $clog2(MAX_DELAY_ARREADY + 1);
    localparam int RTW = $clog2(MAX_DELAY_RVALID + 1);

    localparam logic [QCW-1:0]         Q_FULL = QCW'(CMD_DEPTH);
    localparam logic [OW-1:0]          O_MAX  = OW'(MAX_OUTSTANDING);
    localparam logic [DIW-1:0]         D_LAST = DIW'(MAX_OUTSTANDING - 1);
    localparam logic [ATW-1:0]         AT_MAX = ATW'(MAX_DELAY_ARREADY);
    localparam logic [ATW-1:0]         AT_SET = ATW'(MAX_DELAY_ARREADY - 1);
    localparam logic [RTW-1:0]         RT_MAX = RTW'(MAX_DELAY_RVALID);
    localparam logic [RTW-1:0]         RT_SET = RTW'(MAX_DELAY_RVALID - 1);
    localparam logic [DELAY_WIDTH-1:0] DLY_ONE = DELAY_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ADDR} state_t;

    // command queue
    logic [ADDRESS_WIDTH-1:0] q_addr [CMD_DEPTH];
    logic [2:0]               q_prot [CMD_DEPTH];
    logic [DELAY_WIDTH-1:0]   q_ard  [CMD_DEPTH];
    logic [DELAY_WIDTH-1:0]   q_rrd  [CMD_DEPTH];
    logic [QAW-1:0]           q_wp, q_rp;
    logic [QCW-1:0]           q_cnt, q_cnt_nxt;

    // outstanding-read RREADY delay FIFO, occupancy == outstanding
    logic [DELAY_WIDTH-1:0]   d_fifo [MAX_OUTSTANDING];
    logic [DIW-1:0]           d_wp, d_rp;

    state_t                   state;
    logic [DELAY_WIDTH-1:0]   dcnt, cur_rrd, r_cnt;
    logic                     r_wait;
    logic [ATW-1:0]           at_cnt;
    logic [RTW-1:0]           rt_cnt;
    logic                     push, pop, issue_ok, out_of_range, ar_hs, r_hs;

    // handshake, issue and queue-occupancy decode
    always_comb begin
        push         = cmd_valid && cmd_ready;
        issue_ok     = cfg_blocking ? (outstanding == '0) : (outstanding < O_MAX);
        pop          = (state == S_IDLE) && (q_cnt != '0) && issue_ok;
        out_of_range = (q_addr[q_rp] < cfg_min_addr) || (q_addr[q_rp] > cfg_max_addr);
        ar_hs        = arvalid && arready;
        // a beat with nothing outstanding is never accepted, even if rready idles high
        r_hs         = rvalid && rready && (outstanding != '0);
        q_cnt_nxt    = q_cnt;
        if (push && !pop) q_cnt_nxt = q_cnt + QCW'(1);
        if (pop && !push) q_cnt_nxt = q_cnt - QCW'(1);
    end

    // queue storage writes (no reset needed, guarded by pointers)
    always_ff @(posedge aclk) begin
        if (push) begin
            q_addr[q_wp] <= cmd_addr;
            q_prot[q_wp] <= cmd_prot;
            q_ard[q_wp]  <= cmd_arvalid_delay;
            q_rrd[q_wp]  <= cmd_rready_delay;
        end
    end

    // queue pointers, count and registered cmd_ready
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            q_wp      <= '0;
            q_rp      <= '0;
            q_cnt     <= '0;
            cmd_ready <= 1'b0;
        end else begin
            if (push) q_wp <= q_wp + QAW'(1);
            if (pop)  q_rp <= q_rp + QAW'(1);
            q_cnt     <= q_cnt_nxt;
            cmd_ready <= (q_cnt_nxt != Q_FULL);
        end
    end

    // AR issue FSM: range check on pop, optional delay, hold AR until ready
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            dcnt     <= '0;
            cur_rrd  <= '0;
            araddr   <= '0;
            arprot   <= '0;
            arvalid  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            case (state)
                S_IDLE: if (pop) begin
                    if (out_of_range) begin
                        addr_err <= 1'b1;
                    end else begin
                        araddr  <= q_addr[q_rp];
                        arprot  <= q_prot[q_rp];
                        cur_rrd <= q_rrd[q_rp];
                        if (q_ard[q_rp] == '0) begin
                            state   <= S_ADDR;
                            arvalid <= 1'b1;
                        end else begin
                            state <= S_DELAY;
                            dcnt  <= q_ard[q_rp];
                        end
                    end
                end
                S_DELAY: begin
                    if (dcnt == DLY_ONE) begin
                        state   <= S_ADDR;
                        arvalid <= 1'b1;
                    end else begin
                        dcnt <= dcnt - DLY_ONE;
                    end
                end
                S_ADDR: if (arready) begin
                    arvalid <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // outstanding count and per-read RREADY delay FIFO
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            d_wp        <= '0;
            d_rp        <= '0;
            outstanding <= '0;
        end else begin
            if (ar_hs) begin
                d_fifo[d_wp] <= cur_rrd;
                d_wp         <= (d_wp == D_LAST) ? '0 : d_wp + DIW'(1);
            end
            if (r_hs) d_rp <= (d_rp == D_LAST) ? '0 : d_rp + DIW'(1);
            if (ar_hs && !r_hs) outstanding <= outstanding + OW'(1);
            if (r_hs && !ar_hs) outstanding <= outstanding - OW'(1);
        end
    end

    // RREADY policy: idle-high, or raised D+1 cycles after RVALID is seen
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rready <= 1'b0;
            r_wait <= 1'b0;
            r_cnt  <= '0;
        end else if (DEFAULT_READY != 0) begin
            rready <= 1'b1;
        end else if (r_hs) begin
            rready <= 1'b0;
            r_wait <= 1'b0;
        end else if (r_wait) begin
            if (r_cnt == DLY_ONE) begin
                rready <= 1'b1;
                r_wait <= 1'b0;
            end else begin
                r_cnt <= r_cnt - DLY_ONE;
            end
        end else if (!rready && rvalid && (outstanding != '0)) begin
            if (d_fifo[d_rp] == '0) begin
                rready <= 1'b1;
            end else begin
                r_wait <= 1'b1;
                r_cnt  <= d_fifo[d_rp];
            end
        end
    end

    // completion port: one-cycle pulse with registered beat
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_resp  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= r_hs;
            if (r_hs) begin
                rsp_data <= rdata;
                rsp_resp <= rresp;
                rsp_err  <= (rresp != 2'b00);
            end
        end
    end

    // wait-timeout monitors; a set in the same cycle as tmo_clear wins
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            at_cnt          <= '0;
            rt_cnt          <= '0;
            arready_timeout <= 1'b0;
            rvalid_timeout  <= 1'b0;
        end else begin
            if (arvalid && !arready) begin
                if (at_cnt != AT_MAX) at_cnt <= at_cnt + ATW'(1);
            end else begin
                at_cnt <= '0;
            end
            if ((outstanding != '0) && !rvalid) begin
                if (rt_cnt != RT_MAX) rt_cnt <= rt_cnt + RTW'(1);
            end else begin
                rt_cnt <= '0;
            end
            if (arvalid && !arready && (at_cnt == AT_SET)) arready_timeout <= 1'b1;
            else if (tmo_clear)                            arready_timeout <= 1'b0;
            if ((outstanding != '0) && !rvalid && (rt_cnt == RT_SET)) rvalid_timeout <= 1'b1;
            else if (tmo_clear)                                       rvalid_timeout <= 1'b0;
        end
    end
endmodule
